rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 4: number of sequenced reset domains (range 2..8).
REQ-002 Parameter DLY_WIDTH, default 8: width of each per-domain release delay field.
REQ-003 Parameter HOLD_CYCLES, default 4: minimum cycles all domain resets are held after reset or soft reset (range 1..255).
REQ-004 Parameter TIMEOUT_CYC, default 255: maximum WAIT_ACK cycles before timeout, used only with the timeout macro.
REQ-005 CLK  input  1: single clock; every flop SHALL be rising-edge triggered.
REQ-006 RST  input  1: reset, synchronous, active-high.
REQ-007 SW_RST_REQ  input  1: single-cycle soft-reset request pulse.
REQ-008 DLY_CFG  input  NUM_DOMAINS*DLY_WIDTH: release delay for domain k in bits [k*DLY_WIDTH +: DLY_WIDTH].
REQ-009 DOM_ACK  input  NUM_DOMAINS: per-domain "out of reset" acknowledge, already synchronized to CLK.
REQ-010 DOM_RST_N  output  NUM_DOMAINS: registered active-low domain resets, bit k drives domain k.
REQ-011 SEQ_DONE  output  1: registered; all domains released and acknowledged.
REQ-012 BUSY  output  1: registered; a sequence is in progress.
REQ-013 CUR_DOMAIN  output  3: index of the domain being delayed or awaited; 0 outside DELAY/WAIT_ACK.
REQ-014 TIMEOUT_ERR  output  1: sticky acknowledge-timeout flag.

Function
REQ-015 The FSM SHALL have exactly these states: HOLD, DELAY, WAIT_ACK, RUN, ASSERT.
REQ-016 HOLD SHALL last exactly HOLD_CYCLES edges with DOM_RST_N all 0, then enter DELAY with CUR_DOMAIN=0.
REQ-017 On entering DELAY for domain k, DLY_CFG field k SHALL be sampled once; later changes SHALL be ignored until the next entry.
REQ-018 DELAY SHALL last DLY_CFG[k]+1 edges; on the exiting edge DOM_RST_N[k] SHALL be set to 1 and the FSM SHALL enter WAIT_ACK.
REQ-019 WAIT_ACK SHALL exit on the first edge sampling DOM_ACK[k]=1: to DELAY with k+1 if k<NUM_DOMAINS-1, otherwise to RUN.
REQ-020 On entering RUN, SEQ_DONE SHALL be 1 and BUSY SHALL be 0; BUSY SHALL be 1 in HOLD, DELAY, WAIT_ACK and ASSERT.
REQ-021 DOM_RST_N bits SHALL only rise in ascending index order, and never more than one bit per edge.
REQ-022 In RUN, SW_RST_REQ=1 SHALL enter ASSERT.
REQ-023 ASSERT SHALL last one edge, clearing all DOM_RST_N bits and SEQ_DONE together, then enter HOLD.
REQ-024 SW_RST_REQ SHALL be ignored in every state except RUN; it SHALL not be queued.
REQ-025 DOM_ACK changes outside WAIT_ACK, including ack deassertion in RUN, SHALL be ignored.
REQ-026 DLY_CFG field value 0 SHALL give the minimum 1-edge DELAY; the all-ones value SHALL give 2^DLY_WIDTH edges with no counter wrap.

Reset
REQ-027 RST=1 at a rising edge SHALL set state=HOLD, DOM_RST_N=0, SEQ_DONE=0, BUSY=1, CUR_DOMAIN=0, TIMEOUT_ERR=0, and clear all counters.
REQ-028 RST=1 SHALL override SW_RST_REQ and all states, including mid-sequence and in RUN; the HOLD count SHALL start at the first edge with RST=0.

Configuration
REQ-029 With RST_SEQ_TIMEOUT_EN defined, WAIT_ACK SHALL count edges; after TIMEOUT_CYC edges without an ack it SHALL set TIMEOUT_ERR and advance as if the ack had been seen.
REQ-030 TIMEOUT_ERR SHALL be cleared only by RST, not by soft reset.
REQ-031 Without RST_SEQ_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, TIMEOUT_ERR SHALL be tied 0, and no timeout counter SHALL be synthesized.

Structure
REQ-032 Package rst_seq_pkg SHALL hold the state enum typedef, the default parameter constants and the CUR_DOMAIN width constant.
REQ-033 Sub-module rst_seq_dly_cnt SHALL implement the loadable down-counter shared by HOLD, DELAY and the timeout count; it is the only sub-module.

Verification
REQ-034 Power-up case SHALL be covered: HOLD_CYCLES=4, all DLY_CFG fields 0, DOM_ACK tied 1, RST released -> DOM_RST_N[0] rises 5 edges later, each next bit 2 edges after the previous, SEQ_DONE=1 one edge after DOM_RST_N[3] ack.
REQ-035 Delay case SHALL be covered: DLY_CFG field 1=10, DLY_CFG changed mid-DELAY -> DOM_RST_N[1] rises exactly 11 edges after WAIT_ACK[0] exits; the change has no effect.
REQ-036 Soft-reset case SHALL be covered: SW_RST_REQ pulse in RUN -> next edge DOM_RST_N=0000, SEQ_DONE=0, BUSY=1, then the full sequence repeats; a pulse during DELAY is ignored.
REQ-037 Ack stall case SHALL be covered: DOM_ACK[2] held 0 -> FSM stays in WAIT_ACK with CUR_DOMAIN=2; with the macro and TIMEOUT_CYC=255, TIMEOUT_ERR=1 after 255 edges, the sequence completes, and the flag survives a soft reset.
REQ-038 Mid-sequence reset case SHALL be covered: RST asserted in WAIT_ACK[1] for 1 cycle -> all outputs return to reset values on that edge and the sequence restarts from HOLD.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: state encoding,
// default parameter values and the CUR_DOMAIN output width.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_DELAY,
    ST_WAIT_ACK,
    ST_RUN,
    ST_ASSERT
  } seq_state_e;

  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_DLY_WIDTH   = 8;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int CUR_DOM_W       = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_dly_cnt.sv
// Loadable modulo down-counter shared by the hold, per-domain delay and
// acknowledge-timeout intervals of the reset sequencer.
module rst_seq_dly_cnt
  import rst_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] LOAD_VAL,
  input  logic             DEC,
  output logic [CNT_W-1:0] CNT
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT <= '0;
    end else if (LOAD) begin
      CNT <= LOAD_VAL;
    end else if (DEC) begin
      CNT <= CNT - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Sequenced reset controller: holds all domains, then releases them one by
// one with a per-domain delay and ack handshake. Define RST_SEQ_TIMEOUT_EN
// to add the sticky acknowledge-timeout.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int DLY_WIDTH   = DEF_DLY_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             SW_RST_REQ,
  input  logic [NUM_DOMAINS*DLY_WIDTH-1:0] DLY_CFG,
  input  logic [NUM_DOMAINS-1:0]           DOM_ACK,
  output logic [NUM_DOMAINS-1:0]           DOM_RST_N,
  output logic                             SEQ_DONE,
  output logic                             BUSY,
  output logic [CUR_DOM_W-1:0]             CUR_DOMAIN,
  output logic                             TIMEOUT_ERR
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_W = max3(DLY_WIDTH, 8, $clog2(TIMEOUT_CYC + 1));
  // HOLD counts down from zero through the wrap, so no load is needed
  // after either a hard reset or the ASSERT state.
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(0) - CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q, state_n;
  logic [IDX_W-1:0]       idx_q, idx_n, nxt_idx;
  logic [NUM_DOMAINS-1:0] dom_q, dom_n;
  logic                   done_q, busy_q;
  logic [CUR_DOM_W-1:0]   cur_q, cur_n;
  logic                   adv;
  logic                   cnt_load, cnt_dec;
  logic [CNT_W-1:0]       cnt_val, cnt;
  logic [DLY_WIDTH-1:0]   dly_fld [NUM_DOMAINS];
`ifdef RST_SEQ_TIMEOUT_EN
  logic                   tmo_q, tmo_set;
`endif

  always_comb begin
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      dly_fld[k] = DLY_CFG[k*DLY_WIDTH +: DLY_WIDTH];
    end
  end

  rst_seq_dly_cnt #(.CNT_W(CNT_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (cnt_load),
    .LOAD_VAL (cnt_val),
    .DEC      (cnt_dec),
    .CNT      (cnt)
  );

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    nxt_idx  = idx_q + 1'b1;
    dom_n    = dom_q;
    adv      = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
`ifdef RST_SEQ_TIMEOUT_EN
    tmo_set  = 1'b0;
`endif
    unique case (state_q)
      ST_HOLD: begin
        if (cnt == HOLD_TERM) begin
          state_n  = ST_DELAY;
          idx_n    = '0;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(dly_fld[0]);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt == '0) begin
          dom_n[idx_q] = 1'b1;
          state_n      = ST_WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
          cnt_load     = 1'b1;
          cnt_val      = CNT_W'(TIMEOUT_CYC - 1);
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        adv = DOM_ACK[idx_q];
`ifdef RST_SEQ_TIMEOUT_EN
        if (!adv) begin
          if (cnt == '0) begin
            tmo_set = 1'b1;
            adv     = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
`endif
        if (adv) begin
          if (idx_q == LAST_IDX) begin
            state_n = ST_RUN;
          end else begin
            state_n  = ST_DELAY;
            idx_n    = nxt_idx;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(dly_fld[nxt_idx]);
          end
        end
      end
      ST_RUN: begin
        if (SW_RST_REQ) begin
          state_n = ST_ASSERT;
          dom_n   = '0;
        end
      end
      ST_ASSERT: begin
        state_n  = ST_HOLD;
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
      default: state_n = ST_HOLD;
    endcase
    cur_n = ((state_n == ST_DELAY) || (state_n == ST_WAIT_ACK)) ? CUR_DOM_W'(idx_n) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      cur_q   <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      dom_q   <= dom_n;
      done_q  <= (state_n == ST_RUN);
      busy_q  <= (state_n != ST_RUN);
      cur_q   <= cur_n;
`ifdef RST_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_q | tmo_set;
`endif
    end
  end

  assign DOM_RST_N  = dom_q;
  assign SEQ_DONE   = done_q;
  assign BUSY       = busy_q;
  assign CUR_DOMAIN = cur_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign TIMEOUT_ERR = tmo_q;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector table, directed corner sequences and random
// stimulus against a step-list reference model (RST_SEQ_TIMEOUT_EN aware).
module tb_rst_seq_ctrl;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int HOLD    = 4;
  localparam int TMO_CYC = 255;
  localparam int LAST    = 2 * N;
  localparam int RUNS    = 2 * N + 1;
  localparam int ASRT    = 2 * N + 2;
`ifdef RST_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SW_RST_REQ = 1'b0;
  logic [N*DW-1:0] DLY_CFG = '0;
  logic [N-1:0]  DOM_ACK = '1;
  logic [N-1:0]  DOM_RST_N;
  logic          SEQ_DONE, BUSY, TIMEOUT_ERR;
  logic [2:0]    CUR_DOMAIN;

  rst_seq_ctrl #(
    .NUM_DOMAINS (N),
    .DLY_WIDTH   (DW),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT_CYC (TMO_CYC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SW_RST_REQ  (SW_RST_REQ),
    .DLY_CFG     (DLY_CFG),
    .DOM_ACK     (DOM_ACK),
    .DOM_RST_N   (DOM_RST_N),
    .SEQ_DONE    (SEQ_DONE),
    .BUSY        (BUSY),
    .CUR_DOMAIN  (CUR_DOMAIN),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: step 0 = hold, 2k+1 = delay of domain k, 2k+2 = wait for ack k,
  // RUNS = running, ASRT = soft-reset assert.
  int m_step = 0, m_left = HOLD, m_tw = 0;
  bit m_terr = 1'b0;

  function automatic int fld(input logic [N*DW-1:0] cfg, input int k);
    logic [N*DW-1:0] s;
    s = cfg >> (k * DW);
    return int'(s[DW-1:0]);
  endfunction

  task automatic model_edge(input bit rst, input bit sw, input logic [N*DW-1:0] cfg,
                            input logic [N-1:0] ack);
    int k;
    if (rst) begin
      m_step = 0; m_left = HOLD; m_tw = 0; m_terr = 1'b0;
    end else if (m_step == 0) begin
      m_left--;
      if (m_left == 0) begin
        m_step = 1;
        m_left = fld(cfg, 0) + 1;
      end
    end else if (m_step <= LAST && (m_step % 2) == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_step++;
        m_tw = 0;
      end
    end else if (m_step <= LAST) begin
      k = (m_step - 2) / 2;
      m_tw++;
      if (ack[k] || (TMO_EN && m_tw >= TMO_CYC)) begin
        if (!ack[k]) m_terr = 1'b1;
        m_step++;
        if (m_step <= LAST) m_left = fld(cfg, k + 1) + 1;
      end
    end else if (m_step == RUNS) begin
      if (sw) m_step = ASRT;
    end else begin
      m_step = 0;
      m_left = HOLD;
    end
  endtask

  task automatic step();
    int rel, cur;
    @(posedge CLK);
    model_edge(RST, SW_RST_REQ, DLY_CFG, DOM_ACK);
    #1;
    rel = (m_step >= 1 && m_step <= LAST) ? m_step / 2 : ((m_step == RUNS) ? N : 0);
    cur = (m_step >= 1 && m_step <= LAST) ? (m_step - 1) / 2 : 0;
    chk("mdl_dom_rst_n", 32'(DOM_RST_N), (32'd1 << rel) - 32'd1);
    chk("mdl_seq_done", 32'(SEQ_DONE), 32'(m_step == RUNS));
    chk("mdl_busy", 32'(BUSY), 32'(m_step != RUNS));
    chk("mdl_cur_domain", 32'(CUR_DOMAIN), 32'(cur));
    chk("mdl_timeout_err", 32'(TIMEOUT_ERR), 32'(m_terr));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    SW_RST_REQ = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic wait_for(input logic [2:0] cur, input logic [N-1:0] dom, input int budget,
                          input string nm);
    int n = 0;
    while (!(CUR_DOMAIN === cur && DOM_RST_N === dom) && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(CUR_DOMAIN === cur && DOM_RST_N === dom), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       sw;
    logic [3:0] ack;
    logic [3:0] dom;
    logic       done;
    logic       busy;
    logic [2:0] cur;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic sw, input logic [3:0] ack,
                              input logic [3:0] dom, input logic done, input logic busy,
                              input logic [2:0] cur);
    vec_t v;
    v.rst = rst; v.sw = sw; v.ack = ack; v.dom = dom; v.done = done; v.busy = busy; v.cur = cur;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench time limit reached, checks %0d", checks);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Power-up with zero delays and acks tied high, then soft reset in RUN.
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4'hF, 4'h3, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4'hF, 4'h3, 0, 1, 2));
    tbl.push_back(mk(0, 0, 4'hF, 4'h7, 0, 1, 2));
    tbl.push_back(mk(0, 0, 4'hF, 4'h7, 0, 1, 3));
    tbl.push_back(mk(0, 0, 4'hF, 4'hF, 0, 1, 3));
    tbl.push_back(mk(0, 0, 4'hF, 4'hF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, 1, 0));

    DLY_CFG = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst;
      SW_RST_REQ = tbl[i].sw;
      DOM_ACK = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_dom_rst_n", i), 32'(DOM_RST_N), 32'(tbl[i].dom));
      chk($sformatf("tbl%0d_seq_done", i), 32'(SEQ_DONE), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_cur_domain", i), 32'(CUR_DOMAIN), 32'(tbl[i].cur));
    end
    SW_RST_REQ = 1'b0;

    // Domain 1 delay of 10, config change and soft-reset pulse mid-DELAY.
    DLY_CFG = 32'h0000_0A00;
    DOM_ACK = 4'hF;
    do_reset();
    wait_for(3'd1, 4'h1, 40, "dly_enter_d1");
    for (int i = 1; i <= 11; i++) begin
      if (i == 3) DLY_CFG = 32'h0000_0200;
      SW_RST_REQ = (i == 5);
      step();
      chk($sformatf("dly_dom1_edge%0d", i), 32'(DOM_RST_N[1]), 32'(i == 11));
      if (i == 6) chk("dly_busy_after_sw", 32'(BUSY), 32'd1);
    end
    SW_RST_REQ = 1'b0;

    // All-ones delay field on domain 0: 256 edges.
    DLY_CFG = 32'h0000_00FF;
    do_reset();
    for (int i = 0; i < HOLD; i++) step();
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 255) chk("maxdly_dom0_before", 32'(DOM_RST_N[0]), 32'd0);
      if (i == 256) chk("maxdly_dom0_rise", 32'(DOM_RST_N[0]), 32'd1);
    end

    // Ack stall on domain 2.
    DLY_CFG = '0;
    DOM_ACK = 4'b1011;
    do_reset();
    wait_for(3'd2, 4'h7, 40, "stall_enter_w2");
`ifdef RST_SEQ_TIMEOUT_EN
    for (int j = 1; j <= TMO_CYC; j++) begin
      step();
      if (j == TMO_CYC - 1) begin
        chk("stall_cur_before_tmo", 32'(CUR_DOMAIN), 32'd2);
        chk("stall_err_before_tmo", 32'(TIMEOUT_ERR), 32'd0);
      end
      if (j == TMO_CYC) begin
        chk("stall_err_at_tmo", 32'(TIMEOUT_ERR), 32'd1);
        chk("stall_cur_after_tmo", 32'(CUR_DOMAIN), 32'd3);
      end
    end
    wait_for(3'd0, 4'hF, 20, "tmo_reach_run");
    chk("tmo_seq_done", 32'(SEQ_DONE), 32'd1);
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    chk("tmo_sw_dom", 32'(DOM_RST_N), 32'd0);
    chk("tmo_sticky_sw", 32'(TIMEOUT_ERR), 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("tmo_sticky_later", 32'(TIMEOUT_ERR), 32'd1);
`else
    for (int j = 1; j <= 300; j++) begin
      step();
      if (j == 1 || j == 300) begin
        chk($sformatf("stall_cur_%0d", j), 32'(CUR_DOMAIN), 32'd2);
        chk($sformatf("stall_busy_%0d", j), 32'(BUSY), 32'd1);
        chk($sformatf("stall_err_%0d", j), 32'(TIMEOUT_ERR), 32'd0);
      end
    end
`endif

    // RST asserted for one cycle while waiting on domain 1.
    DOM_ACK = 4'b1101;
    do_reset();
    wait_for(3'd1, 4'h3, 40, "mid_enter_w1");
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_dom", 32'(DOM_RST_N), 32'd0);
    chk("mid_rst_done", 32'(SEQ_DONE), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd1);
    chk("mid_rst_cur", 32'(CUR_DOMAIN), 32'd0);
    chk("mid_rst_err", 32'(TIMEOUT_ERR), 32'd0);
    DOM_ACK = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("mid_restart_edge%0d", i), 32'(DOM_RST_N), 32'(i == 5));
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 499) == 0);
      SW_RST_REQ = ($urandom_range(0, 11) == 0);
      DOM_ACK = 4'($urandom_range(0, 15));
      DLY_CFG = 32'($urandom) & 32'h0707_0707;
      step();
    end
    RST = 1'b0;
    SW_RST_REQ = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
